// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared types and constants for the writeback arbiter and its slow-path FIFO.
//   REG_ADDR_W / DATA_W : register file address and data widths
//   REG_ZERO            : hard-wired zero register, never written
//   wb_entry_t          : one writeback candidate {valid, rd, data}
//   is_write()          : true when an entry produces a real register write
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   // A candidate reaches the register file only if it is still live and does
   // not target the zero register.
   function automatic logic is_write(input wb_entry_t e);
      return e.valid && (e.rd != REG_ZERO);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Circular buffer holding slow-path (multiply/load) results until the write
// port is free. Each entry carries its own valid bit so that a younger ALU
// write can kill older results to the same register without removing them:
// killed entries keep their slot and later pop as no-ops.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   push, push_rd/data  : enqueue one result (caller guarantees room)
//   pop                 : dequeue the head (caller guarantees non-empty)
//   kill_en, kill_rd    : invalidate every stored entry, and the entry being
//                         pushed this cycle, whose rd equals kill_rd
//   head                : entry at the read pointer
//   full, empty, count  : occupancy derived from the count, not the pointers
// -----------------------------------------------------------------------------
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           push,
   input  logic [REG_ADDR_W-1:0]          push_rd,
   input  logic [DATA_W-1:0]              push_data,
   input  logic                           pop,
   input  logic                           kill_en,
   input  logic [REG_ADDR_W-1:0]          kill_rd,
   output wb_entry_t                      head,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
   logic [REG_ADDR_W-1:0] rd_d   [DEPTH];
   logic [DATA_W-1:0]     data_q [DEPTH];
   logic [DATA_W-1:0]     data_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      valid_d  = valid_q;
      rd_d     = rd_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;

      if (kill_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_q[i] == kill_rd) valid_d[i] = 1'b0;
         end
      end

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end

      // Push is applied after pop so that, when full, the slot freed by the
      // pop can be refilled in the same cycle.
      if (push) begin
         valid_d[wr_ptr_q] = !(kill_en && (push_rd == kill_rd));
         rd_d[wr_ptr_q]    = push_rd;
         data_d[wr_ptr_q]  = push_data;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops
   // sample the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the payload array is not reset; the per-entry valid bits and the
   // occupancy count already make stale payload unreachable.
   always_ff @(posedge clk) begin
      rd_q   <= rd_d;
      data_q <= data_d;
   end

   assign head  = '{valid: valid_q[rd_ptr_q], rd: rd_q[rd_ptr_q], data: data_q[rd_ptr_q]};
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Owns the register file write port. Each cycle it writes either the
// single-cycle ALU result or the head of the slow-path FIFO, with the ALU
// taking priority. ALU writes kill older buffered results to the same
// register. If the FIFO stays full while the ALU keeps winning, a one-cycle
// aluStall is raised so the head can drain.
//
// Ports
//   clk, reset                     : clock, asynchronous active-high reset
//   aluValid, aluRd, aluData       : ALU result (held upstream while stalled)
//   aluStall                       : registered one-cycle ALU hold request
//   mulValid/mulReady, mulRd/Data  : slow-path valid/ready push interface
//   regWr, rW, busWIn              : registered register file write port
//   mulPending                     : FIFO occupancy, killed entries included
// -----------------------------------------------------------------------------
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        aluValid,
   input  logic [REG_ADDR_W-1:0]       aluRd,
   input  logic [DATA_W-1:0]           aluData,
   input  logic                        mulValid,
   output logic                        mulReady,
   input  logic [REG_ADDR_W-1:0]       mulRd,
   input  logic [DATA_W-1:0]           mulData,
   output logic                        aluStall,
   output logic                        regWr,
   output logic [REG_ADDR_W-1:0]       rW,
   output logic [DATA_W-1:0]           busWIn,
   output logic [$clog2(DEPTH+1)-1:0]  mulPending
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT+1);

   wb_entry_t             fifo_head;
   logic                  fifo_full, fifo_empty;
   logic                  fifo_push, fifo_pop;
   logic                  alu_win, kill_en;
   wb_entry_t             sel;

   logic                  reg_wr_q, reg_wr_d;
   logic [REG_ADDR_W-1:0] rw_q, rw_d;
   logic [DATA_W-1:0]     bus_w_q, bus_w_d;
   logic                  alu_stall_q, alu_stall_d;
   logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;

   // Ready depends only on pre-edge occupancy, so a full FIFO refuses a push
   // even in a cycle where it pops.
   assign mulReady  = !fifo_full && !reset;
   assign fifo_push = mulValid && mulReady;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_rd   (mulRd),
      .push_data (mulData),
      .pop       (fifo_pop),
      .kill_en   (kill_en),
      .kill_rd   (aluRd),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (mulPending)
   );

   always_comb begin
      alu_win  = aluValid && !alu_stall_q;
      // A killed head still occupies the slot, so any non-empty FIFO pops
      // when the ALU is idle; is_write() then suppresses the write.
      fifo_pop = !alu_win && !fifo_empty;
      kill_en  = alu_win && (aluRd != REG_ZERO);

      if (alu_win)       sel = '{valid: 1'b1, rd: aluRd, data: aluData};
      else if (fifo_pop) sel = fifo_head;
      else               sel = '0;

      reg_wr_d = is_write(sel);
      rw_d     = reg_wr_d ? sel.rd   : rw_q;
      bus_w_d  = reg_wr_d ? sel.data : bus_w_q;

      starve_cnt_d = starve_cnt_q;
      alu_stall_d  = 1'b0;
      if (fifo_pop) begin
         starve_cnt_d = '0;
      end else if (fifo_full && alu_win) begin
         if (starve_cnt_q == STARVE_W'(STARVE_LIMIT-1)) begin
            alu_stall_d  = 1'b1;
            starve_cnt_d = '0;
         end else begin
            starve_cnt_d = starve_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_wr_q     <= 1'b0;
         rw_q         <= '0;
         bus_w_q      <= '0;
         alu_stall_q  <= 1'b0;
         starve_cnt_q <= '0;
      end else begin
         reg_wr_q     <= reg_wr_d;
         rw_q         <= rw_d;
         bus_w_q      <= bus_w_d;
         alu_stall_q  <= alu_stall_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign regWr    = reg_wr_q;
   assign rW       = rw_q;
   assign busWIn   = bus_w_q;
   assign aluStall = alu_stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
// Directed bench for wb_arbiter (DEPTH=2, STARVE_LIMIT=4). Inputs change 1 ns
// after each rising edge; outputs are sampled at that same point, so a check
// after tick() sees the write selected in the cycle just completed.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        aluValid;
   logic [4:0]  aluRd;
   logic [31:0] aluData;
   logic        mulValid;
   logic        mulReady;
   logic [4:0]  mulRd;
   logic [31:0] mulData;
   logic        aluStall;
   logic        regWr;
   logic [4:0]  rW;
   logic [31:0] busWIn;
   logic [1:0]  mulPending;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .aluValid   (aluValid),
      .aluRd      (aluRd),
      .aluData    (aluData),
      .mulValid   (mulValid),
      .mulReady   (mulReady),
      .mulRd      (mulRd),
      .mulData    (mulData),
      .aluStall   (aluStall),
      .regWr      (regWr),
      .rW         (rW),
      .busWIn     (busWIn),
      .mulPending (mulPending)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
      aluValid = v;
      aluRd    = rd;
      aluData  = d;
   endtask

   task automatic set_mul(input logic v, input logic [4:0] rd, input logic [31:0] d);
      mulValid = v;
      mulRd    = rd;
      mulData  = d;
   endtask

   task automatic check_wr(input string tag, input logic wr, input logic [4:0] rd,
                           input logic [31:0] d);
      check({tag, "_regWr"}, 32'(regWr), 32'(wr));
      check({tag, "_rW"}, 32'(rW), 32'(rd));
      check({tag, "_busWIn"}, busWIn, d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      set_alu(1'b0, 5'd0, 32'h0);
      set_mul(1'b0, 5'd0, 32'h0);
      tick();
      tick();

      // Reset state
      check_wr("rst", 1'b0, 5'd0, 32'h0);
      check("rst_stall", 32'(aluStall), 32'd0);
      check("rst_pending", 32'(mulPending), 32'd0);
      check("rst_ready", 32'(mulReady), 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_ready", 32'(mulReady), 32'd1);

      // ALU-only stream: three writes to r5, one cycle latency
      set_alu(1'b1, 5'd5, 32'hA5A5A5A5);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_wr($sformatf("alu_stream%0d", i), 1'b1, 5'd5, 32'hA5A5A5A5);
         check($sformatf("alu_stream%0d_stall", i), 32'(aluStall), 32'd0);
      end
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check_wr("alu_hold", 1'b0, 5'd5, 32'hA5A5A5A5);

      // Slow path with idle ALU: r7 then r8, in order
      set_mul(1'b1, 5'd7, 32'h1234);
      tick();
      check_wr("mul_push7", 1'b0, 5'd5, 32'hA5A5A5A5);
      check("mul_push7_pend", 32'(mulPending), 32'd1);
      set_mul(1'b1, 5'd8, 32'h5678);
      tick();
      check_wr("mul_wr7", 1'b1, 5'd7, 32'h1234);
      check("mul_wr7_pend", 32'(mulPending), 32'd1);
      set_mul(1'b0, 5'd0, 32'h0);
      tick();
      check_wr("mul_wr8", 1'b1, 5'd8, 32'h5678);
      check("mul_wr8_pend", 32'(mulPending), 32'd0);
      tick();
      check("mul_idle_wr", 32'(regWr), 32'd0);

      // Kill: buffered r3 result is superseded by a younger ALU write
      set_mul(1'b1, 5'd3, 32'hDEAD);
      tick();
      check("kill_push_pend", 32'(mulPending), 32'd1);
      set_mul(1'b0, 5'd0, 32'h0);
      set_alu(1'b1, 5'd3, 32'hBEEF);
      tick();
      check_wr("kill_alu", 1'b1, 5'd3, 32'hBEEF);
      check("kill_alu_pend", 32'(mulPending), 32'd1);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check_wr("kill_pop", 1'b0, 5'd3, 32'hBEEF);
      check("kill_pop_pend", 32'(mulPending), 32'd0);

      // Kill of the entry pushed in the same cycle as the ALU write
      set_mul(1'b1, 5'd9, 32'h1111);
      set_alu(1'b1, 5'd9, 32'h2222);
      tick();
      check_wr("kill_same", 1'b1, 5'd9, 32'h2222);
      check("kill_same_pend", 32'(mulPending), 32'd1);
      set_mul(1'b0, 5'd0, 32'h0);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check_wr("kill_same_pop", 1'b0, 5'd9, 32'h2222);
      check("kill_same_pop_pend", 32'(mulPending), 32'd0);

      // Register 0: neither source writes, slow entry still popped
      set_alu(1'b1, 5'd0, 32'hFFFFFFFF);
      set_mul(1'b1, 5'd0, 32'hCAFE);
      tick();
      check_wr("r0_alu", 1'b0, 5'd9, 32'h2222);
      check("r0_alu_pend", 32'(mulPending), 32'd1);
      set_alu(1'b0, 5'd0, 32'h0);
      set_mul(1'b0, 5'd0, 32'h0);
      tick();
      check_wr("r0_pop", 1'b0, 5'd9, 32'h2222);
      check("r0_pop_pend", 32'(mulPending), 32'd0);

      // Starvation: fill FIFO behind a busy ALU
      set_alu(1'b1, 5'd10, 32'hA0);
      set_mul(1'b1, 5'd1, 32'h100);
      tick();
      check_wr("starve_fill0", 1'b1, 5'd10, 32'hA0);
      set_alu(1'b1, 5'd11, 32'hA1);
      set_mul(1'b1, 5'd2, 32'h200);
      tick();
      check_wr("starve_fill1", 1'b1, 5'd11, 32'hA1);
      check("starve_full_pend", 32'(mulPending), 32'd2);
      check("starve_full_ready", 32'(mulReady), 32'd0);
      // A third result is offered throughout but must not be accepted
      set_mul(1'b1, 5'd4, 32'h400);
      for (int i = 0; i < 4; i++) begin
         set_alu(1'b1, 5'(12 + i), 32'(32'hB0 + i));
         tick();
         check_wr($sformatf("starve_blk%0d", i), 1'b1, 5'(12 + i), 32'(32'hB0 + i));
         check($sformatf("starve_blk%0d_stall", i), 32'(aluStall), (i == 3) ? 32'd1 : 32'd0);
         check($sformatf("starve_blk%0d_pend", i), 32'(mulPending), 32'd2);
      end
      // Stall cycle: ALU input ignored, head r1 written
      set_alu(1'b1, 5'd20, 32'hEEEE);
      check("stall_ready", 32'(mulReady), 32'd0);
      tick();
      check_wr("stall_head", 1'b1, 5'd1, 32'h100);
      check("stall_clear", 32'(aluStall), 32'd0);
      check("stall_pend", 32'(mulPending), 32'd1);
      set_mul(1'b0, 5'd0, 32'h0);
      set_alu(1'b1, 5'd21, 32'hA21);
      tick();
      check_wr("post_stall_alu", 1'b1, 5'd21, 32'hA21);
      check("post_stall_pend", 32'(mulPending), 32'd1);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check_wr("drain_r2", 1'b1, 5'd2, 32'h200);
      check("drain_pend", 32'(mulPending), 32'd0);

      // Reset mid-operation with FIFO full and ALU valid
      set_alu(1'b1, 5'd14, 32'hC0);
      set_mul(1'b1, 5'd5, 32'h500);
      tick();
      set_alu(1'b1, 5'd15, 32'hC1);
      set_mul(1'b1, 5'd6, 32'h600);
      tick();
      check_wr("pre_rst", 1'b1, 5'd15, 32'hC1);
      check("pre_rst_pend", 32'(mulPending), 32'd2);
      set_alu(1'b1, 5'd16, 32'hC2);
      set_mul(1'b1, 5'd7, 32'h700);
      reset = 1'b1;
      #1;
      check_wr("mid_rst", 1'b0, 5'd0, 32'h0);
      check("mid_rst_pend", 32'(mulPending), 32'd0);
      check("mid_rst_ready", 32'(mulReady), 32'd0);
      check("mid_rst_stall", 32'(aluStall), 32'd0);
      tick();
      reset = 1'b0;
      set_alu(1'b0, 5'd0, 32'h0);
      set_mul(1'b0, 5'd0, 32'h0);
      tick();
      check_wr("after_rst", 1'b0, 5'd0, 32'h0);
      check("after_rst_pend", 32'(mulPending), 32'd0);
      set_alu(1'b1, 5'd13, 32'h1313);
      tick();
      check_wr("first_wr", 1'b1, 5'd13, 32'h1313);
      set_alu(1'b0, 5'd0, 32'h0);
      tick();
      check("final_idle", 32'(regWr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
